// File: rtl/dest_fifo_pair_if.sv
// Router/consumer signal bundle for the dual destination FIFO stage.
// The slave modport is the FIFO side, the master modport is the router/consumer side.
interface dest_fifo_pair_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  push_D0;
    logic                  push_D1;
    logic [DATA_WIDTH-1:0] data_in_D0;
    logic [DATA_WIDTH-1:0] data_in_D1;
    logic                  D0_pop;
    logic                  D1_pop;
    logic [DATA_WIDTH-1:0] data_out_D0;
    logic [DATA_WIDTH-1:0] data_out_D1;
    logic                  valid_out_D0;
    logic                  valid_out_D1;
    logic                  full_D0;
    logic                  full_D1;
    logic                  empty_D0;
    logic                  empty_D1;
    logic                  almost_full_D0;
    logic                  almost_full_D1;
    logic                  almost_empty_D0;
    logic                  almost_empty_D1;
    logic                  pause;
    logic                  error_D0;
    logic                  error_D1;

    // Handshake: a push/pop strobe is consumed on the rising edge it is sampled;
    // valid_out is high for exactly one cycle after each accepted pop.
    modport slave (
        input  push_D0, push_D1, data_in_D0, data_in_D1, D0_pop, D1_pop,
        output data_out_D0, data_out_D1, valid_out_D0, valid_out_D1,
               full_D0, full_D1, empty_D0, empty_D1,
               almost_full_D0, almost_full_D1, almost_empty_D0, almost_empty_D1,
               pause, error_D0, error_D1
    );

    modport master (
        output push_D0, push_D1, data_in_D0, data_in_D1, D0_pop, D1_pop,
        input  data_out_D0, data_out_D1, valid_out_D0, valid_out_D1,
               full_D0, full_D1, empty_D0, empty_D1,
               almost_full_D0, almost_full_D1, almost_empty_D0, almost_empty_D1,
               pause, error_D0, error_D1
    );
endinterface

// File: rtl/dest_fifo_pair.sv
// Two independent destination FIFOs (D0, D1) with registered pop data,
// occupancy/threshold flags, router backpressure and sticky protocol errors.
module dest_fifo_pair #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    dest_fifo_pair_if.slave         bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [1:0]            w_push;
    logic [1:0]            w_pop;
    logic [DATA_WIDTH-1:0] w_din [2];

    assign w_push   = {bus.push_D1, bus.push_D0};
    assign w_pop    = {bus.D1_pop, bus.D0_pop};
    assign w_din[0] = bus.data_in_D0;
    assign w_din[1] = bus.data_in_D1;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [ADDR_WIDTH-1:0] r_wr_ptr;
        logic [ADDR_WIDTH-1:0] r_rd_ptr;
        logic [ADDR_WIDTH:0]   r_count;
        logic [DATA_WIDTH-1:0] r_data_out;
        logic                  r_valid_out;
        logic                  r_error;
        logic                  w_full;
        logic                  w_empty;
        logic                  w_af;
        logic                  w_ae;
        logic                  w_pop_acc;
        logic                  w_push_acc;
        logic                  w_err_evt;

        assign w_full     = (r_count == CNT_FULL);
        assign w_empty    = (r_count == '0);
        assign w_af       = (r_count >= CNT_AF);
        assign w_ae       = (r_count <= CNT_AE);
        assign w_pop_acc  = w_pop[ch] && !w_empty;
        // A pop frees a slot in the same edge, so a full FIFO can still take a push.
        assign w_push_acc = w_push[ch] && (!w_full || w_pop_acc);
        assign w_err_evt  = (w_pop[ch] && w_empty) || (w_push[ch] && !w_push_acc);

        // Storage is not reset: stale contents are unreachable once the pointers clear.
        always_ff @(posedge clk) begin
            if (w_push_acc) begin
                r_mem[r_wr_ptr] <= w_din[ch];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_data_out  <= '0;
                r_valid_out <= 1'b0;
                r_error     <= 1'b0;
            end else begin
                r_valid_out <= w_pop_acc;
                if (w_pop_acc) begin
                    r_data_out <= r_mem[r_rd_ptr];
                    r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                end
                if (w_push_acc) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_push_acc && !w_pop_acc) begin
                    r_count <= r_count + CNT_ONE;
                end else if (w_pop_acc && !w_push_acc) begin
                    r_count <= r_count - CNT_ONE;
                end
                if (w_err_evt) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out_D0     = g_ch[0].r_data_out;
    assign bus.data_out_D1     = g_ch[1].r_data_out;
    assign bus.valid_out_D0    = g_ch[0].r_valid_out;
    assign bus.valid_out_D1    = g_ch[1].r_valid_out;
    assign bus.full_D0         = g_ch[0].w_full;
    assign bus.full_D1         = g_ch[1].w_full;
    assign bus.empty_D0        = g_ch[0].w_empty;
    assign bus.empty_D1        = g_ch[1].w_empty;
    assign bus.almost_full_D0  = g_ch[0].w_af;
    assign bus.almost_full_D1  = g_ch[1].w_af;
    assign bus.almost_empty_D0 = g_ch[0].w_ae;
    assign bus.almost_empty_D1 = g_ch[1].w_ae;
    assign bus.pause           = g_ch[0].w_af | g_ch[1].w_af;
    assign bus.error_D0        = g_ch[0].r_error;
    assign bus.error_D1        = g_ch[1].r_error;
endmodule

// File: tb/tb_dest_fifo_pair.sv
// Self-checking bench for dest_fifo_pair: directed test-plan sequences plus random
// traffic, checked against a queue-based reference model with a decoupled output monitor.
module tb_dest_fifo_pair;
    localparam int W     = 6;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    dest_fifo_pair_if #(.DATA_WIDTH(W)) bus ();

    dest_fifo_pair #(
        .DATA_WIDTH(W), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- per-channel output views ----------------
    logic [W-1:0] o_dout  [2];
    logic         o_valid [2];
    logic         o_full  [2];
    logic         o_empty [2];
    logic         o_af    [2];
    logic         o_ae    [2];
    logic         o_err   [2];

    assign o_dout[0]  = bus.data_out_D0;     assign o_dout[1]  = bus.data_out_D1;
    assign o_valid[0] = bus.valid_out_D0;    assign o_valid[1] = bus.valid_out_D1;
    assign o_full[0]  = bus.full_D0;         assign o_full[1]  = bus.full_D1;
    assign o_empty[0] = bus.empty_D0;        assign o_empty[1] = bus.empty_D1;
    assign o_af[0]    = bus.almost_full_D0;  assign o_af[1]    = bus.almost_full_D1;
    assign o_ae[0]    = bus.almost_empty_D0; assign o_ae[1]    = bus.almost_empty_D1;
    assign o_err[0]   = bus.error_D0;        assign o_err[1]   = bus.error_D1;

    // ---------------- reference model + scoreboard ----------------
    logic [W-1:0] mdl_q [2][$];   // words the model holds in each FIFO
    logic [W-1:0] exp_q [2][$];   // words expected on data_out, in order
    logic         mdl_err [2];
    logic [W-1:0] last_out [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int ch = 0; ch < 2; ch++) begin
            mdl_q[ch].delete();
            exp_q[ch].delete();
            mdl_err[ch]  = 1'b0;
            last_out[ch] = '0;
        end
    endtask

    task automatic model_ch(input int ch, input logic p, input logic [W-1:0] d, input logic q);
        int n;
        bit pop_ok;
        bit push_ok;
        n       = mdl_q[ch].size();
        pop_ok  = q && (n > 0);
        push_ok = p && ((n < DEPTH) || pop_ok);
        if ((q && n == 0) || (p && !push_ok)) mdl_err[ch] = 1'b1;
        if (pop_ok)  exp_q[ch].push_back(mdl_q[ch].pop_front());
        if (push_ok) mdl_q[ch].push_back(d);
    endtask

    task automatic check_flags();
        int n;
        for (int ch = 0; ch < 2; ch++) begin
            n = mdl_q[ch].size();
            chk($sformatf("full_D%0d", ch),         32'(o_full[ch]),  32'(n == DEPTH));
            chk($sformatf("empty_D%0d", ch),        32'(o_empty[ch]), 32'(n == 0));
            chk($sformatf("almost_full_D%0d", ch),  32'(o_af[ch]),    32'(n >= 3));
            chk($sformatf("almost_empty_D%0d", ch), 32'(o_ae[ch]),    32'(n <= 1));
            chk($sformatf("error_D%0d", ch),        32'(o_err[ch]),   32'(mdl_err[ch]));
        end
        chk("pause", 32'(bus.pause), 32'((mdl_q[0].size() >= 3) || (mdl_q[1].size() >= 3)));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (o_valid[ch]) begin
                    if (exp_q[ch].size() == 0) begin
                        chk($sformatf("unexpected_valid_D%0d", ch), 32'(o_valid[ch]), 32'd0);
                    end else begin
                        chk($sformatf("data_out_D%0d", ch), 32'(o_dout[ch]), 32'(exp_q[ch].pop_front()));
                    end
                    last_out[ch] = o_dout[ch];
                end else begin
                    if (exp_q[ch].size() != 0) begin
                        chk($sformatf("missing_valid_D%0d", ch), 32'(o_valid[ch]), 32'd1);
                        void'(exp_q[ch].pop_front());
                    end
                    chk($sformatf("data_hold_D%0d", ch), 32'(o_dout[ch]), 32'(last_out[ch]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic p0, input logic [W-1:0] d0, input logic q0,
                        input logic p1, input logic [W-1:0] d1, input logic q1);
        bus.push_D0 = p0; bus.data_in_D0 = d0; bus.D0_pop = q0;
        bus.push_D1 = p1; bus.data_in_D1 = d1; bus.D1_pop = q1;
        @(posedge clk);
        model_ch(0, p0, d0, q0);
        model_ch(1, p1, d1, q1);
        #1;
        bus.push_D0 = 1'b0; bus.D0_pop = 1'b0;
        bus.push_D1 = 1'b0; bus.D1_pop = 1'b0;
        check_flags();
    endtask

    task automatic push0(input logic [W-1:0] d); step(1'b1, d, 1'b0, 1'b0, '0, 1'b0); endtask
    task automatic push1(input logic [W-1:0] d); step(1'b0, '0, 1'b0, 1'b1, d, 1'b0); endtask
    task automatic pop0(); step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0); endtask
    task automatic pop1(); step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1); endtask
    task automatic idle(); step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0); endtask

    task automatic drain_all();
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            if (mdl_q[0].size() == 0 && mdl_q[1].size() == 0) break;
            step(1'b0, '0, mdl_q[0].size() > 0, 1'b0, '0, mdl_q[1].size() > 0);
        end
        idle();
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic async_reset_check();
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            chk($sformatf("rst_empty_D%0d", ch),  32'(o_empty[ch]), 32'd1);
            chk($sformatf("rst_ae_D%0d", ch),     32'(o_ae[ch]),    32'd1);
            chk($sformatf("rst_full_D%0d", ch),   32'(o_full[ch]),  32'd0);
            chk($sformatf("rst_af_D%0d", ch),     32'(o_af[ch]),    32'd0);
            chk($sformatf("rst_error_D%0d", ch),  32'(o_err[ch]),   32'd0);
            chk($sformatf("rst_dout_D%0d", ch),   32'(o_dout[ch]),  32'd0);
            chk($sformatf("rst_valid_D%0d", ch),  32'(o_valid[ch]), 32'd0);
        end
        chk("rst_pause", 32'(bus.pause), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        bus.push_D0 = 1'b0; bus.data_in_D0 = '0; bus.D0_pop = 1'b0;
        bus.push_D1 = 1'b0; bus.data_in_D1 = '0; bus.D1_pop = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        async_reset_check();

        // Fill and drain D0
        push0(6'b110100);
        push0(6'b100101);
        push0(6'b110110);
        chk("pause_after_3rd_push", 32'(bus.pause), 32'd1);
        push0(6'b101100);
        chk("full_after_4th_push", 32'(bus.full_D0), 32'd1);
        drain_all();

        // Overflow on D0
        push0(6'h01); push0(6'h02); push0(6'h03); push0(6'h04);
        push0(6'b111101);
        chk("overflow_error_D0", 32'(bus.error_D0), 32'd1);
        chk("overflow_error_D1", 32'(bus.error_D1), 32'd0);
        drain_all();

        // Full push+pop on D1
        push1(6'h11); push1(6'h12); push1(6'h13); push1(6'h14);
        step(1'b0, '0, 1'b0, 1'b1, 6'b010110, 1'b1);
        chk("full_pushpop_full_D1", 32'(bus.full_D1), 32'd1);
        chk("full_pushpop_err_D1", 32'(bus.error_D1), 32'd0);
        drain_all();

        // Underflow on D1, then push+pop while empty
        pop1();
        chk("underflow_valid_D1", 32'(bus.valid_out_D1), 32'd0);
        chk("underflow_error_D1", 32'(bus.error_D1), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 6'h2a, 1'b1);
        chk("empty_pushpop_stored", 32'(bus.empty_D1), 32'd0);
        idle();

        // Reset mid-operation with data buffered and errors set
        push0(6'h05); push0(6'h06);
        async_reset_check();
        idle();

        // Pointer wrap: interleaved push/pop pairs on D0
        for (int i = 0; i < 10; i++) begin
            push0(W'(6'h20 + i));
            pop0();
        end
        idle();
        chk("wrap_error_D0", 32'(bus.error_D0), 32'd0);

        // Random traffic on both channels
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end
        drain_all();
        idle();
        chk("final_exp_q_D0", 32'(exp_q[0].size()), 32'd0);
        chk("final_exp_q_D1", 32'(exp_q[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dest_fifo_pair.md
# dest_fifo_pair

Dual destination-FIFO stage that sits directly downstream of the transmit-layer final routing logic. It receives the routed 6-bit words destined for D0 and D1, buffers each in an independent FIFO, and presents them to the D0/D1 consumers through a pop interface. It also reports occupancy flags and a `pause` backpressure signal to the upstream router, and flags protocol errors.

## Interface
Parameters:
- `DATA_WIDTH`, 6, word width; bits [5:4] carry class/destination tag and are passed through untouched.
- `ADDR_WIDTH`, 2, FIFO depth = 2**ADDR_WIDTH (4 entries).
- `AF_THRESH`, 3, almost-full threshold; `almost_full` is asserted when count >= AF_THRESH.
- `AE_THRESH`, 1, almost-empty threshold; `almost_empty` is asserted when count <= AE_THRESH.

Ports. Reset is asynchronous and active-high (`reset`); there is a single clock `clk`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: async active-high reset.
- `push_D0`, `push_D1` in 1 each: write strobe from the router.
- `data_in_D0`, `data_in_D1` in DATA_WIDTH each: write data.
- `D0_pop`, `D1_pop` in 1 each: consumer read strobe.
- `data_out_D0`, `data_out_D1` out DATA_WIDTH each: registered read data.
- `valid_out_D0`, `valid_out_D1` out 1 each: data_out holds a word popped in the previous cycle.
- `full_D0`, `full_D1`, `empty_D0`, `empty_D1` out 1 each: occupancy flags.
- `almost_full_D0`, `almost_full_D1`, `almost_empty_D0`, `almost_empty_D1` out 1 each: threshold flags.
- `pause` out 1: `almost_full_D0 | almost_full_D1`; the router must stop pushing.
- `error_D0`, `error_D1` out 1 each: sticky protocol error.

## Operation
- The two channels are fully independent and identical. The description below is per channel.
- Storage is a DEPTH x DATA_WIDTH register array with a write pointer, a read pointer (ADDR_WIDTH bits, natural wrap at DEPTH-1 -> 0), and `count` (ADDR_WIDTH+1 bits, range 0..DEPTH).
- Push accepted when `push && (!full || pop_accepted)`. The write is to `mem[wr_ptr]`, then `wr_ptr++`.
- Pop accepted when `pop && !empty`. On the next edge, `data_out <= mem[rd_ptr]`, `valid_out <= 1`, and `rd_ptr++`.
- When no pop is accepted, `valid_out <= 0` and `data_out` holds its last value.
- Count update:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on both or neither.
- Simultaneous push and pop when full: both are accepted and count stays DEPTH.
- Simultaneous push and pop when empty: the push is accepted, the pop is rejected (no bypass), and `error` is set.
- Push while full with no pop: the word is dropped, no pointer or count changes, and `error` is set.
- Pop while empty: ignored and `error` is set.
- `error` is sticky until `reset`.
- Flags are combinational from `count`:
  - full = (count == DEPTH);
  - empty = (count == 0);
  - almost_full = (count >= AF_THRESH);
  - almost_empty = (count <= AE_THRESH).
- Reset values: all pointers and counts 0, data_out 0, valid_out 0, error 0. Therefore empty = 1, almost_empty = 1, full = 0, almost_full = 0, pause = 0.
- Reset asserted mid-operation immediately clears all state; buffered contents are discarded.

## Timing
- Write-to-readable latency: a word pushed at edge N is poppable at edge N+1. It appears on `data_out` after the pop edge, with 1-cycle read latency.
- Flags and `pause` reflect count after the current edge, in the same cycle with no extra register stage.
- Throughput: 1 push and 1 pop per channel per cycle sustained.
- Backpressure: `pause` asserts one entry before full (default AF_THRESH=3). The router honours it on the next edge, so one in-flight push is absorbed without overflow.
- `error` rises on the edge that samples the offending strobe.

## Test plan
- **Reset:** assert `reset` asynchronously between edges. The outputs clear at once: empty = 1, almost_empty = 1, full = 0, error = 0, data_out = 0, valid_out = 0.
- **Fill and drain D0:** push 6'b110100, 6'b100101, 6'b110110, 6'b101100.
  - After the 3rd push: almost_full_D0 = 1 and pause = 1.
  - After the 4th push: full_D0 = 1.
  - Four pops return the same sequence on data_out_D0 with valid_out_D0 = 1, each one cycle after its pop. empty_D0 = 1 at the end.
- **Overflow:** with D0 full, push 6'b111101 without a pop. error_D0 = 1, count stays 4, and the drained data excludes 6'b111101. D1 is unaffected (error_D1 = 0).
- **Full push+pop:** with D1 full, assert push_D1 (6'b010110) and D1_pop together. The first-written word is output, full_D1 stays 1, error_D1 = 0, and 6'b010110 emerges last.
- **Underflow:** pop D1 when empty. error_D1 = 1, valid_out_D1 = 0, and data_out_D1 is unchanged. Push and pop when empty: the word is stored (empty_D1 = 0) and error_D1 = 1.
- **Pointer wrap:** run 10 interleaved push/pop pairs on D0 with distinct values. Output order matches input order across pointer wrap, and error_D0 = 0.
